// File: rtl/bus_arbiter_if.sv
// Bus-arbiter signal bundle: driver requests and payloads, grants, and the
// external bus request/available handshake with its driven outputs.
interface bus_arbiter_if #(
   parameter int NDRV = 4,
   parameter int AW   = 16,
   parameter int DW   = 8
) ();
   localparam int OW = $clog2(NDRV);

   logic [NDRV-1:0]    req;
   logic [NDRV-1:0]    gnt;
   logic [NDRV*AW-1:0] drv_a;
   logic [NDRV*DW-1:0] drv_d;
   logic [NDRV-1:0]    drv_rw;
   logic [NDRV-1:0]    drv_if;
   logic               br;
   logic               ba;
   logic [AW-1:0]      a_out;
   logic [DW-1:0]      d_out;
   logic               d_oe;
   logic               rw_out;
   logic               if_out;
   logic               dt_out;
   logic [OW-1:0]      owner;

   modport master (
      output req, drv_a, drv_d, drv_rw, drv_if, ba,
      input  gnt, br, a_out, d_out, d_oe, rw_out, if_out, dt_out, owner
   );

   modport slave (
      input  req, drv_a, drv_d, drv_rw, drv_if, ba,
      output gnt, br, a_out, d_out, d_oe, rw_out, if_out, dt_out, owner
   );
endinterface

// File: rtl/bus_arbiter.sv
// Multi-driver external bus arbiter: requests BR, waits for BA, grants one
// driver (round-robin or fixed priority) with a bounded hold and turnaround.
module bus_arbiter #(
   parameter int NDRV    = 4,
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int RR      = 1,
   parameter int MAXHOLD = 16
) (
   input  logic         clk,
   input  logic         rst,
   bus_arbiter_if.slave bus
);
   localparam int OW = $clog2(NDRV);
   localparam int CW = $clog2(MAXHOLD + 2);
   // Counter stops at the last allowed cycle so a late requester still preempts.
   localparam logic [CW-1:0] HOLD_LAST = (MAXHOLD == 0) ? {CW{1'b1}} : CW'(MAXHOLD - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT_BA = 2'd1;
   localparam logic [1:0] OWN     = 2'd2;
   localparam logic [1:0] TURN    = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [OW-1:0] owner;
   logic [OW-1:0] winner;
   logic [CW-1:0] hold_cnt;
   logic          br_q;
   logic          any_req;
   logic          others_req;
   logic          own;

   assign any_req    = |bus.req;
   assign own        = (state == OWN);
   assign others_req = |(bus.req & ~(NDRV'(1) << owner));

   // Later loop iterations override earlier ones, so iterate from lowest priority up.
   always_comb begin
      winner = owner;
      if (RR != 0) begin
         for (int k = NDRV; k >= 1; k--) begin
            if (bus.req[(int'(owner) + k) % NDRV]) winner = OW'((int'(owner) + k) % NDRV);
         end
      end else begin
         for (int i = NDRV - 1; i >= 0; i--) begin
            if (bus.req[i]) winner = OW'(i);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (any_req) state_nxt = WAIT_BA;
         end
         WAIT_BA: begin
            if (!any_req)    state_nxt = IDLE;
            else if (bus.ba) state_nxt = OWN;
         end
         OWN: begin
            if (!bus.req[owner] || !bus.ba ||
                ((MAXHOLD != 0) && (hold_cnt == HOLD_LAST) && others_req))
               state_nxt = TURN;
         end
         default: begin
            state_nxt = any_req ? WAIT_BA : IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= OW'(NDRV - 1);
         hold_cnt <= '0;
         br_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         br_q  <= (state_nxt != IDLE);
         if ((state == WAIT_BA) && (state_nxt == OWN)) begin
            owner    <= winner;
            hold_cnt <= '0;
         end else if (own && (hold_cnt != HOLD_LAST)) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   assign bus.br     = br_q;
   assign bus.owner  = owner;
   assign bus.gnt    = own ? (NDRV'(1) << owner) : '0;
   assign bus.a_out  = own ? bus.drv_a[int'(owner)*AW +: AW] : '0;
   assign bus.d_out  = own ? bus.drv_d[int'(owner)*DW +: DW] : '0;
   assign bus.d_oe   = own & ~bus.drv_rw[owner];
   assign bus.rw_out = own ? bus.drv_rw[owner] : 1'b1;
   assign bus.if_out = own & bus.drv_if[owner];
   assign bus.dt_out = own & (owner != '0);
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a round-robin instance (MAXHOLD=4) and a
// fixed-priority instance share one stimulus stream.
module tb_bus_arbiter;
   logic clk;
   logic rst;
   int   vecs = 0;
   int   miscompares = 0;

   bus_arbiter_if #(.NDRV(4), .AW(16), .DW(8)) bi_rr ();
   bus_arbiter_if #(.NDRV(4), .AW(16), .DW(8)) bi_fp ();

   bus_arbiter #(.NDRV(4), .AW(16), .DW(8), .RR(1), .MAXHOLD(4)) dut_rr (
      .clk(clk), .rst(rst), .bus(bi_rr.slave)
   );
   bus_arbiter #(.NDRV(4), .AW(16), .DW(8), .RR(0), .MAXHOLD(16)) dut_fp (
      .clk(clk), .rst(rst), .bus(bi_fp.slave)
   );

   assign bi_fp.req    = bi_rr.req;
   assign bi_fp.drv_a  = bi_rr.drv_a;
   assign bi_fp.drv_d  = bi_rr.drv_d;
   assign bi_fp.drv_rw = bi_rr.drv_rw;
   assign bi_fp.drv_if = bi_rr.drv_if;
   assign bi_fp.ba     = bi_rr.ba;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] exp_gnt;
      rst          = 1'b1;
      bi_rr.req    = 4'b0000;
      bi_rr.ba     = 1'b0;
      bi_rr.drv_a  = 64'hD3A3_D2A2_D1A1_D0A0;
      bi_rr.drv_d  = 32'h4433_2211;
      bi_rr.drv_rw = 4'b1111;
      bi_rr.drv_if = 4'b0101;

      // reset state
      tick(2);
      check("rst_br", bi_rr.br, 1'b0);
      check("rst_gnt", bi_rr.gnt, 4'b0000);
      check("rst_d_oe", bi_rr.d_oe, 1'b0);
      check("rst_a_out", bi_rr.a_out, 16'h0000);
      check("rst_d_out", bi_rr.d_out, 8'h00);
      check("rst_rw_out", bi_rr.rw_out, 1'b1);
      check("rst_if_out", bi_rr.if_out, 1'b0);
      check("rst_dt_out", bi_rr.dt_out, 1'b0);
      check("rst_owner_rr", bi_rr.owner, 2'd3);
      check("rst_owner_fp", bi_fp.owner, 2'd3);
      rst = 1'b0;
      tick(1);
      check("idle_br", bi_rr.br, 1'b0);

      // single request, BA arrives at cycle 2
      bi_rr.req = 4'b0001;
      tick(1);
      check("single_c1_br", bi_rr.br, 1'b1);
      check("single_c1_gnt", bi_rr.gnt, 4'b0000);
      tick(1);
      check("single_c2_gnt", bi_rr.gnt, 4'b0000);
      bi_rr.ba = 1'b1;
      tick(1);
      check("single_c3_gnt", bi_rr.gnt, 4'b0001);
      check("single_owner", bi_rr.owner, 2'd0);
      check("single_a_out", bi_rr.a_out, 16'hD0A0);
      check("single_dt_out", bi_rr.dt_out, 1'b0);
      check("single_if_out", bi_rr.if_out, 1'b1);
      check("single_rw_out", bi_rr.rw_out, 1'b1);
      check("single_d_oe_rd", bi_rr.d_oe, 1'b0);
      bi_rr.drv_a[15:0] = 16'h1234;
      bi_rr.drv_rw[0]   = 1'b0;
      #1;
      check("single_a_follow", bi_rr.a_out, 16'h1234);
      check("single_d_oe_wr", bi_rr.d_oe, 1'b1);
      check("single_d_out", bi_rr.d_out, 8'h11);
      check("single_rw_wr", bi_rr.rw_out, 1'b0);
      bi_rr.drv_rw[0] = 1'b1;
      bi_rr.req       = 4'b0000;
      tick(1);
      check("single_turn_gnt", bi_rr.gnt, 4'b0000);
      check("single_turn_br", bi_rr.br, 1'b1);
      check("single_turn_d_oe", bi_rr.d_oe, 1'b0);
      tick(1);
      check("single_idle_br", bi_rr.br, 1'b0);

      // round-robin rotation with MAXHOLD=4
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      bi_rr.req = 4'b1111;
      tick(1);
      check("rr_wait_gnt", bi_rr.gnt, 4'b0000);
      check("rr_wait_br", bi_rr.br, 1'b1);
      tick(1);
      for (int k = 0; k < 28; k++) begin
         exp_gnt = ((k % 6) < 4) ? (4'b0001 << ((k / 6) % 4)) : 4'b0000;
         check($sformatf("rr_gnt_k%0d", k), bi_rr.gnt, exp_gnt);
         tick(1);
      end
      bi_rr.req = 4'b0000;
      tick(2);

      // fixed priority
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      bi_rr.req = 4'b1010;
      tick(2);
      check("fp_gnt1", bi_fp.gnt, 4'b0010);
      check("fp_owner1", bi_fp.owner, 2'd1);
      check("fp_dt1", bi_fp.dt_out, 1'b1);
      check("fp_a1", bi_fp.a_out, 16'hD1A1);
      check("fp_d1", bi_fp.d_out, 8'h22);
      bi_rr.req = 4'b1011;
      tick(1);
      check("fp_no_preempt", bi_fp.gnt, 4'b0010);
      bi_rr.req = 4'b1000;
      tick(1);
      check("fp_turn_gnt", bi_fp.gnt, 4'b0000);
      check("fp_turn_d_oe", bi_fp.d_oe, 1'b0);
      tick(1);
      check("fp_wait_gnt", bi_fp.gnt, 4'b0000);
      check("fp_wait_br", bi_fp.br, 1'b1);
      tick(1);
      check("fp_gnt3", bi_fp.gnt, 4'b1000);
      check("fp_owner3", bi_fp.owner, 2'd3);
      check("fp_dt3", bi_fp.dt_out, 1'b1);
      check("fp_a3", bi_fp.a_out, 16'hD3A3);
      bi_rr.req = 4'b0000;
      tick(2);

      // revocation of driver 2, then hold past MAXHOLD alone
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      bi_rr.req = 4'b0100;
      tick(2);
      check("rev_gnt", bi_rr.gnt, 4'b0100);
      check("rev_owner", bi_rr.owner, 2'd2);
      bi_rr.ba = 1'b0;
      tick(1);
      check("rev_turn_gnt", bi_rr.gnt, 4'b0000);
      check("rev_turn_br", bi_rr.br, 1'b1);
      tick(1);
      check("rev_wait_gnt", bi_rr.gnt, 4'b0000);
      check("rev_wait_br", bi_rr.br, 1'b1);
      bi_rr.ba = 1'b1;
      tick(1);
      check("rev_regrant", bi_rr.gnt, 4'b0100);
      tick(6);
      check("hold_alone", bi_rr.gnt, 4'b0100);
      bi_rr.req = 4'b0001;
      tick(1);
      check("hold_turn", bi_rr.gnt, 4'b0000);
      tick(2);
      check("rr_wrap_gnt", bi_rr.gnt, 4'b0001);
      bi_rr.req = 4'b0000;
      tick(2);

      // abandon before BA
      bi_rr.ba  = 1'b0;
      bi_rr.req = 4'b0100;
      tick(1);
      check("abandon_br1", bi_rr.br, 1'b1);
      bi_rr.req = 4'b0000;
      tick(1);
      check("abandon_br0", bi_rr.br, 1'b0);
      check("abandon_gnt", bi_rr.gnt, 4'b0000);
      tick(1);
      check("abandon_gnt2", bi_rr.gnt, 4'b0000);
      check("abandon_owner", bi_rr.owner, 2'd0);

      // reset while driver 1 owns the bus and writes
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      bi_rr.ba     = 1'b1;
      bi_rr.drv_rw = 4'b1101;
      bi_rr.req    = 4'b0010;
      tick(2);
      check("rstown_gnt", bi_rr.gnt, 4'b0010);
      check("rstown_d_oe", bi_rr.d_oe, 1'b1);
      check("rstown_d_out", bi_rr.d_out, 8'h22);
      rst = 1'b1;
      tick(1);
      check("rstown_gnt0", bi_rr.gnt, 4'b0000);
      check("rstown_d_oe0", bi_rr.d_oe, 1'b0);
      check("rstown_br0", bi_rr.br, 1'b0);
      check("rstown_owner", bi_rr.owner, 2'd3);
      check("rstown_a0", bi_rr.a_out, 16'h0000);
      rst = 1'b0;
      bi_rr.req = 4'b0000;
      tick(1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NDRV, default 4, number of bus drivers (2..8).
REQ-002 Parameter AW, default 16, address width; DW, default 8, data width.
REQ-003 Parameter RR, default 1; 1 = round-robin arbitration, 0 = fixed priority with driver 0 highest.
REQ-004 Parameter MAXHOLD, default 16; maximum consecutive owned cycles while another driver requests; 0 = unlimited.
REQ-005 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-006 CLK  in  1  system clock; all state changes on rising edge.
REQ-007 RST  in  1  synchronous active-high reset.
REQ-008 REQ  in  NDRV  per-driver bus request, level.
REQ-009 GNT  out  NDRV  per-driver bus available, one-hot or zero.
REQ-010 DRV_A  in  NDRV*AW  packed driver addresses, driver i at [i*AW +: AW].
REQ-011 DRV_D  in  NDRV*DW  packed driver write data.
REQ-012 DRV_RW  in  NDRV  per-driver read(1)/write(0).
REQ-013 DRV_IF  in  NDRV  per-driver instruction-fetch flag.
REQ-014 BR  out  1  external bus request.
REQ-015 BA  in  1  external bus available.
REQ-016 A_OUT  out  AW; D_OUT  out  DW; D_OE  out  1; RW_OUT  out  1; IF_OUT  out  1; DT_OUT  out  1: external bus drive.
REQ-017 OWNER  out  clog2(NDRV)  index of current or last owner.

Function
REQ-018 FSM states: IDLE, WAIT_BA, OWN, TURN.
REQ-019 IDLE: any REQ high -> WAIT_BA next cycle; BR registered, 1 from that cycle.
REQ-020 WAIT_BA: winner recomputed combinationally every cycle from current REQ.
REQ-021 WAIT_BA with BA=1 and any REQ: latch winner into OWNER, GNT[winner]=1 next cycle, -> OWN.
REQ-022 WAIT_BA with REQ all zero: -> IDLE, BR=0 next cycle, no grant.
REQ-023 Fixed priority: lowest-index requesting driver wins.
REQ-024 Round-robin: first requester searching upward from OWNER+1, wrapping from NDRV-1 to 0.
REQ-025 OWN: A_OUT, D_OUT, RW_OUT, IF_OUT mux owner's DRV_* combinationally; D_OE = ~owner RW; DT_OUT=1 iff OWNER != 0.
REQ-026 Outside OWN: GNT=0, A_OUT=0, D_OUT=0, D_OE=0, RW_OUT=1, IF_OUT=0, DT_OUT=0.
REQ-027 Hold counter clears on entering OWN, increments each OWN cycle, saturates.
REQ-028 OWN -> TURN when: REQ[OWNER]=0; or BA=0 (revocation); or MAXHOLD!=0, count = MAXHOLD-1 and another REQ high.
REQ-029 Simultaneous exit conditions: single transition to TURN; no priority distinction needed.
REQ-030 MAXHOLD expiry with no other requester: owner keeps the bus, counter saturates.
REQ-031 TURN lasts exactly one cycle, all GNT=0, D_OE=0 (bus turnaround).
REQ-032 TURN -> WAIT_BA if any REQ high (BR stays 1), else -> IDLE (BR=0 next cycle).
REQ-033 WAIT_BA entered with BA already 1 grants on the following edge (TURN to next GNT = 2 cycles).
REQ-034 GNT is never high for two drivers in the same cycle, and never high while BA was 0 in the previous cycle.
REQ-035 REQ rising on a non-owner during OWN has no effect until TURN.

Reset
REQ-036 RST=1: state IDLE; BR=0; GNT=0; D_OE=0; A_OUT=0; D_OUT=0; RW_OUT=1; IF_OUT=0; DT_OUT=0; hold counter 0.
REQ-037 RST=1: OWNER=NDRV-1, so round-robin first grants driver 0.
REQ-038 RST asserted in OWN releases the bus on the next edge without a TURN cycle.

Verification
REQ-039 Single request: REQ=0001 at cycle 0, BA=1 at cycle 2 -> BR=1 at cycle 1, GNT=0001 at cycle 3, A_OUT follows DRV_A[0], DT_OUT=0.
REQ-040 Round-robin: REQ=1111 held, MAXHOLD=4, BA=1 -> grant order 0,1,2,3,0; each GNT 4 cycles, 1-cycle TURN plus 1-cycle WAIT_BA between grants.
REQ-041 Fixed priority (RR=0): REQ=1010 -> driver 1 granted; after it drops, driver 3 granted; DT_OUT=1 for both.
REQ-042 Revocation: BA 1->0 during OWN of driver 2 -> TURN next cycle, GNT=0, BR remains 1; BA=1 again -> driver 2 regranted 1 cycle later.
REQ-043 Abandon: REQ=0100 then 0000 before BA -> IDLE, BR=0, GNT never set.
REQ-044 Reset mid-OWN: RST=1 while driver 1 owns the bus, with RW=0 -> next edge GNT=0, D_OE=0, BR=0, OWNER=NDRV-1.
